// File: rtl/aes_iter_core.sv
// Iterative AES-128/AES-256 encryption core: one round per clock, round keys
// expanded on the fly from a rolling window of Nk key words.
module aes_iter_core #(
    parameter int KEY_WIDTH = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [127:0]         i_block,
    input  logic [KEY_WIDTH-1:0] key,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [127:0]         o_block,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);

    localparam int NK = KEY_WIDTH / 32;
    localparam int NR = (KEY_WIDTH == 256) ? 14 : 10;
    localparam logic [3:0] NR4 = 4'(NR);

    generate
        if (KEY_WIDTH != 128 && KEY_WIDTH != 256) begin : g_badWidth
            $error("aes_iter_core: KEY_WIDTH must be 128 or 256");
        end
    endgenerate

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

    fsm_t r_fsm, w_fsmNext;

    logic [127:0]     r_state;
    logic [NK*32-1:0] r_key;
    logic [3:0]       r_roundCnt;
    logic [127:0]     r_oBlock;

    logic [127:0]     w_sub, w_shift, w_mix, w_roundOut, w_roundKey, w_newWords;
    logic [NK*32-1:0] w_keyNext;
    logic [31:0]      w_lastWord, w_tmp, w_new0, w_new1, w_new2, w_new3;
    logic [3:0]       w_rconIdx;
    logic             w_rotType, w_useDirect, w_lastRound;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        // byte x sits at bits 2047-8x down to 2040-8x, i.e. {~x, 3'b111}
        return SBOX[{~x, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] subWord(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] mixColumn(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // State byte n is row n%4, column n/4; ShiftRows rotates row r left by r.
    always_comb begin
        w_sub   = '0;
        w_shift = '0;
        w_mix   = '0;
        for (int n = 0; n < 16; n++) begin
            w_sub[127 - 8*n -: 8] = sbox(r_state[127 - 8*n -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_shift[127 - 8*(4*c + r) -: 8] = w_sub[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            w_mix[127 - 32*c -: 32] = mixColumn(w_shift[127 - 32*c -: 32]);
        end
    end

    // AES-256 round 1 uses w[4..7] as-is; every other round derives four new words.
    always_comb begin
        w_lastWord  = r_key[31:0];
        w_rotType   = (NK == 4) || !r_roundCnt[0];
        w_rconIdx   = (NK == 4) ? (r_roundCnt - 4'd1) : ((r_roundCnt >> 1) - 4'd1);
        w_tmp       = w_rotType ? (subWord({w_lastWord[23:0], w_lastWord[31:24]}) ^ {rcon(w_rconIdx), 24'h000000})
                                : subWord(w_lastWord);
        w_new0      = r_key[NK*32-1  -: 32] ^ w_tmp;
        w_new1      = r_key[NK*32-33 -: 32] ^ w_new0;
        w_new2      = r_key[NK*32-65 -: 32] ^ w_new1;
        w_new3      = r_key[NK*32-97 -: 32] ^ w_new2;
        w_newWords  = {w_new0, w_new1, w_new2, w_new3};
        w_useDirect = (NK == 8) && (r_roundCnt == 4'd1);
        w_roundKey  = w_useDirect ? r_key[127:0] : w_newWords;
        w_lastRound = (r_roundCnt == NR4);
        w_roundOut  = (w_lastRound ? w_shift : w_mix) ^ w_roundKey;
    end

    generate
        if (NK == 4) begin : g_window4
            assign w_keyNext = w_newWords;
        end else begin : g_window8
            assign w_keyNext = {r_key[127:0], w_newWords};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fsm <= IDLE;
        end else begin
            r_fsm <= w_fsmNext;
        end
    end

    always_comb begin
        w_fsmNext = r_fsm;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_fsm)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_fsmNext = ROUND;
            end
            ROUND: begin
                busy = 1'b1;
                if (w_lastRound) w_fsmNext = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_fsmNext = IDLE;
            end
            default: w_fsmNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= '0;
            r_key      <= '0;
            r_roundCnt <= '0;
            r_oBlock   <= '0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (in_valid) begin
                        r_state    <= i_block ^ key[KEY_WIDTH-1 -: 128];
                        r_key      <= key;
                        r_roundCnt <= 4'd1;
                    end
                end
                ROUND: begin
                    r_state <= w_roundOut;
                    if (!w_useDirect) r_key <= w_keyNext;
                    if (w_lastRound) begin
                        r_oBlock   <= w_roundOut;
                        r_roundCnt <= 4'd0;
                    end else begin
                        r_roundCnt <= r_roundCnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_block = r_oBlock;

endmodule

// File: tb/tb_aes_iter_core.sv
// Directed bench for aes_iter_core: FIPS-197 style known-answer vectors on a
// 128-bit and a 256-bit instance, plus reset, backpressure and streaming cases.
module tb_aes_iter_core;

    logic clk = 1'b0;
    logic reset;

    logic [127:0] blk128, key128, out128;
    logic         iv128, ir128, ov128, or128, busy128;

    logic [127:0] blk256, out256;
    logic [255:0] key256;
    logic         iv256, ir256, ov256, or256, busy256;

    int nTotal = 0;
    int nBad   = 0;

    logic [127:0] vKey[3];
    logic [127:0] vPt[3];
    logic [127:0] vCt[3];

    aes_iter_core #(.KEY_WIDTH(128)) dut128 (
        .clk(clk), .reset(reset), .i_block(blk128), .key(key128),
        .in_valid(iv128), .in_ready(ir128), .o_block(out128),
        .out_valid(ov128), .out_ready(or128), .busy(busy128)
    );

    aes_iter_core #(.KEY_WIDTH(256)) dut256 (
        .clk(clk), .reset(reset), .i_block(blk256), .key(key256),
        .in_valid(iv256), .in_ready(ir256), .o_block(out256),
        .out_valid(ov256), .out_ready(or256), .busy(busy256)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        iv128 = 1'b1;
        iv256 = 1'b1;
        blk128 = vPt[0];
        key128 = vKey[0];
        blk256 = vPt[0];
        key256 = {vKey[0], 128'h101112131415161718191a1b1c1d1e1f};
        tick;
        tick;
        nTotal++;
        if ({ir128, ov128, busy128} !== 3'b100) begin
            nBad++;
            $display("[TB] FAIL reset128_flags: got %b expected 100", {ir128, ov128, busy128});
        end
        nTotal++;
        if (out128 !== 128'h0) begin
            nBad++;
            $display("[TB] FAIL reset128_oblock: got %h expected 0", out128);
        end
        nTotal++;
        if ({ir256, ov256, busy256} !== 3'b100) begin
            nBad++;
            $display("[TB] FAIL reset256_flags: got %b expected 100", {ir256, ov256, busy256});
        end
        nTotal++;
        if (out256 !== 128'h0) begin
            nBad++;
            $display("[TB] FAIL reset256_oblock: got %h expected 0", out256);
        end
        reset = 1'b0;
        iv128 = 1'b0;
        iv256 = 1'b0;
        tick;
        nTotal++;
        if (busy128 !== 1'b0) begin
            nBad++;
            $display("[TB] FAIL reset_no_accept: busy got %b expected 0", busy128);
        end
    endtask

    task automatic run128(input logic [127:0] k, input logic [127:0] p, input logic [127:0] c, input string name);
        int edges;
        edges  = 0;
        key128 = k;
        blk128 = p;
        iv128  = 1'b1;
        or128  = 1'b0;
        tick;
        iv128  = 1'b0;
        blk128 = {$urandom, $urandom, $urandom, $urandom};
        key128 = {$urandom, $urandom, $urandom, $urandom};
        nTotal++;
        if ({busy128, ir128} !== 2'b10) begin
            nBad++;
            $display("[TB] FAIL %s_busy: got %b expected 10", name, {busy128, ir128});
        end
        while (!ov128 && edges < 20) begin
            tick;
            edges++;
        end
        nTotal++;
        if (edges !== 10) begin
            nBad++;
            $display("[TB] FAIL %s_latency: got %0d expected 10", name, edges);
        end
        nTotal++;
        if (out128 !== c) begin
            nBad++;
            $display("[TB] FAIL %s_ct: got %h expected %h", name, out128, c);
        end
        or128 = 1'b1;
        tick;
        or128 = 1'b0;
        nTotal++;
        if ({ir128, ov128, busy128} !== 3'b100) begin
            nBad++;
            $display("[TB] FAIL %s_release: got %b expected 100", name, {ir128, ov128, busy128});
        end
    endtask

    task automatic test_aes128;
        run128(vKey[0], vPt[0], vCt[0], "kat128_a");
        run128(vKey[1], vPt[1], vCt[1], "kat128_b");
        run128(vKey[2], vPt[2], vCt[2], "kat128_zero");
    endtask

    task automatic test_aes256;
        int edges;
        edges  = 0;
        key256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        blk256 = 128'h00112233445566778899aabbccddeeff;
        iv256  = 1'b1;
        or256  = 1'b0;
        tick;
        iv256  = 1'b0;
        key256 = '0;
        blk256 = '0;
        while (!ov256 && edges < 24) begin
            tick;
            edges++;
        end
        nTotal++;
        if (edges !== 14) begin
            nBad++;
            $display("[TB] FAIL kat256_latency: got %0d expected 14", edges);
        end
        nTotal++;
        if (out256 !== 128'h8ea2b7ca516745bfeafc49904b496089) begin
            nBad++;
            $display("[TB] FAIL kat256_ct: got %h expected 8ea2b7ca516745bfeafc49904b496089", out256);
        end
        or256 = 1'b1;
        tick;
        or256 = 1'b0;
        nTotal++;
        if ({ir256, ov256} !== 2'b10) begin
            nBad++;
            $display("[TB] FAIL kat256_release: got %b expected 10", {ir256, ov256});
        end
    endtask

    task automatic test_backpressure;
        int waitCnt;
        waitCnt = 0;
        key128 = vKey[0];
        blk128 = vPt[0];
        iv128  = 1'b1;
        or128  = 1'b0;
        tick;
        iv128  = 1'b0;
        while (!ov128 && waitCnt < 20) begin
            tick;
            waitCnt++;
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                key128 = vKey[1];
                blk128 = vPt[1];
                iv128  = 1'b1;
            end
            tick;
            iv128 = 1'b0;
            nTotal++;
            if ({ov128, ir128} !== 2'b10 || out128 !== vCt[0]) begin
                nBad++;
                $display("[TB] FAIL bp_hold%0d: got ov/ir=%b o=%h expected 10 %h", i, {ov128, ir128}, out128, vCt[0]);
            end
        end
        or128 = 1'b1;
        tick;
        or128 = 1'b0;
        nTotal++;
        if ({ir128, ov128} !== 2'b10 || out128 !== vCt[0]) begin
            nBad++;
            $display("[TB] FAIL bp_release: got ir/ov=%b o=%h expected 10 %h", {ir128, ov128}, out128, vCt[0]);
        end
        tick;
        nTotal++;
        if (busy128 !== 1'b0) begin
            nBad++;
            $display("[TB] FAIL bp_pulse_ignored: busy got %b expected 0", busy128);
        end
    endtask

    task automatic test_reset_midround;
        logic seen;
        seen   = 1'b0;
        key128 = vKey[1];
        blk128 = vPt[1];
        iv128  = 1'b1;
        or128  = 1'b1;
        tick;
        iv128 = 1'b0;
        repeat (4) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        nTotal++;
        if ({ir128, ov128, busy128} !== 3'b100 || out128 !== 128'h0) begin
            nBad++;
            $display("[TB] FAIL midreset_state: got flags=%b o=%h expected 100 0", {ir128, ov128, busy128}, out128);
        end
        for (int i = 0; i < 14; i++) begin
            tick;
            if (ov128) seen = 1'b1;
        end
        nTotal++;
        if (seen !== 1'b0) begin
            nBad++;
            $display("[TB] FAIL midreset_discard: out_valid seen %b expected 0", seen);
        end
        or128 = 1'b0;
        run128(vKey[0], vPt[0], vCt[0], "after_reset");
    endtask

    task automatic test_back_to_back;
        localparam int N = 12;
        int inIdx;
        int outIdx;
        logic extra;
        inIdx  = 0;
        outIdx = 0;
        extra  = 1'b0;
        blk128 = vPt[0];
        key128 = vKey[0];
        iv128  = 1'b1;
        or128  = 1'($urandom_range(0, 1));
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (ov128 && or128) begin
                nTotal++;
                if (out128 !== vCt[outIdx % 3]) begin
                    nBad++;
                    $display("[TB] FAIL b2b_out%0d: got %h expected %h", outIdx, out128, vCt[outIdx % 3]);
                end
                outIdx++;
            end
            if (ir128 && iv128) inIdx++;
            tick;
            if (outIdx >= N) break;
            if (inIdx < N) begin
                blk128 = vPt[inIdx % 3];
                key128 = vKey[inIdx % 3];
                iv128  = 1'b1;
            end else begin
                iv128 = 1'b0;
            end
            or128 = 1'($urandom_range(0, 1));
        end
        iv128 = 1'b0;
        or128 = 1'b1;
        nTotal++;
        if (outIdx !== N) begin
            nBad++;
            $display("[TB] FAIL b2b_count: got %0d expected %0d", outIdx, N);
        end
        for (int i = 0; i < 20; i++) begin
            tick;
            if (ov128) extra = 1'b1;
        end
        nTotal++;
        if (extra !== 1'b0) begin
            nBad++;
            $display("[TB] FAIL b2b_extra_output: got %b expected 0", extra);
        end
        or128 = 1'b0;
    endtask

    initial begin
        vKey[0] = 128'h000102030405060708090a0b0c0d0e0f;
        vPt[0]  = 128'h00112233445566778899aabbccddeeff;
        vCt[0]  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        vKey[1] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        vPt[1]  = 128'h3243f6a8885a308d313198a2e0370734;
        vCt[1]  = 128'h3925841d02dc09fbdc118597196a0b32;
        vKey[2] = 128'h0;
        vPt[2]  = 128'h0;
        vCt[2]  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
        reset = 1'b0;
        iv128 = 1'b0;
        or128 = 1'b0;
        iv256 = 1'b0;
        or256 = 1'b0;
        blk128 = '0;
        key128 = '0;
        blk256 = '0;
        key256 = '0;
        $display("[TB] starting aes_iter_core bench");
        test_reset;
        test_aes128;
        test_aes256;
        test_backpressure;
        test_reset_midround;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", nTotal, nBad);
        $finish;
    end

endmodule
